// File: rtl/simon_pkg.sv
// Shared types and helpers for the Simon button front end.
package simon_pkg;

    localparam int NUM_BTN = 4;

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        REPORT,
        RELEASE
    } btn_state_t;

    typedef logic [1:0] btn_idx_t;

    function automatic logic [2:0] count_set(input logic [NUM_BTN-1:0] v);
        count_set = '0;
        for (int unsigned i = 0; i < NUM_BTN; i++) begin
            count_set = count_set + 3'(v[i]);
        end
    endfunction

    function automatic btn_idx_t onehot_idx(input logic [NUM_BTN-1:0] v);
        onehot_idx = '0;
        for (int unsigned i = 0; i < NUM_BTN; i++) begin
            if (v[i]) begin
                onehot_idx = btn_idx_t'(i);
            end
        end
    endfunction

endpackage

// File: rtl/simon_ms_tick.sv
// Millisecond tick generator; the period is latched whenever the count restarts.
module simon_ms_tick (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ticks_per_ms,
    input  logic        restart,
    output logic        tick
);

    logic [15:0] r_cnt;
    logic [15:0] r_limit;
    logic [15:0] w_limit_in;
    logic        w_wrap;

    assign w_limit_in = (ticks_per_ms == '0) ? 16'd1 : ticks_per_ms;
    // >= keeps the counter from running away if the latched limit ever shrinks
    assign w_wrap     = (r_cnt >= (r_limit - 16'd1));
    assign tick       = w_wrap && !restart;

    always_ff @(posedge clk) begin
        if (rst || restart) begin
            r_cnt   <= '0;
            r_limit <= w_limit_in;
        end else if (w_wrap) begin
            r_cnt   <= '0;
            r_limit <= w_limit_in;
        end else begin
            r_cnt   <= r_cnt + 16'd1;
        end
    end

endmodule

// File: rtl/simon_button_decoder.sv
// Debounces four player buttons into single press events with a valid/ready handshake.
module simon_button_decoder #(
    parameter int DEBOUNCE_MS = 20,
    parameter int NUM_BTN     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [15:0]           ticks_per_ms,
    input  logic [NUM_BTN-1:0]    btn_inputs,
    output logic                  press_valid,
    output simon_pkg::btn_idx_t   press_idx,
    input  logic                  press_ready,
    output logic                  press_error
);

    import simon_pkg::*;

    localparam int            CW      = (DEBOUNCE_MS > 0) ? $clog2(DEBOUNCE_MS + 1) : 1;
    localparam logic [CW-1:0] MS_LAST = CW'(DEBOUNCE_MS - 1);

    if (DEBOUNCE_MS < 1) begin : g_bad_debounce
        $error("simon_button_decoder: DEBOUNCE_MS must be at least 1");
    end
    if (NUM_BTN != 4) begin : g_bad_num_btn
        $error("simon_button_decoder: NUM_BTN must be 4");
    end

    logic [NUM_BTN-1:0] r_sync1;
    logic [NUM_BTN-1:0] r_sync2;
    btn_state_t         r_state;
    logic [CW-1:0]      r_ms;
    logic               r_restart;
    logic               r_multi_seen;

    logic               w_tick;
    logic [2:0]         w_nset;
    logic               w_multi;
    logic [NUM_BTN-1:0] w_captured;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= btn_inputs;
            r_sync2 <= r_sync1;
        end
    end

    assign w_nset  = count_set(r_sync2);
    assign w_multi = (w_nset > 3'd1);

    always_comb begin
        w_captured            = '0;
        w_captured[press_idx] = 1'b1;
    end

    // r_restart is registered, so the tick is masked for the first cycle of each new state
    simon_ms_tick u_ms_tick (
        .clk          (clk),
        .rst          (rst),
        .ticks_per_ms (ticks_per_ms),
        .restart      (r_restart),
        .tick         (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_ms         <= '0;
            r_restart    <= 1'b0;
            r_multi_seen <= 1'b0;
            press_valid  <= 1'b0;
            press_idx    <= '0;
            press_error  <= 1'b0;
        end else begin
            r_restart    <= 1'b0;
            press_error  <= 1'b0;
            r_multi_seen <= w_multi && (r_state == IDLE);
            case (r_state)
                IDLE: begin
                    if (w_nset == 3'd1) begin
                        press_idx <= onehot_idx(r_sync2);
                        r_ms      <= '0;
                        r_restart <= 1'b1;
                        r_state   <= DEBOUNCE;
                    end else if (w_multi && !r_multi_seen) begin
                        press_error <= 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (r_sync2 != w_captured) begin
                        press_error  <= w_multi;
                        r_multi_seen <= w_multi;
                        r_ms         <= '0;
                        r_restart    <= 1'b1;
                        r_state      <= IDLE;
                    end else if (w_tick) begin
                        if (r_ms == MS_LAST) begin
                            press_valid <= 1'b1;
                            r_ms        <= '0;
                            r_restart   <= 1'b1;
                            r_state     <= REPORT;
                        end else begin
                            r_ms <= r_ms + 1'b1;
                        end
                    end
                end
                REPORT: begin
                    if (press_ready) begin
                        press_valid <= 1'b0;
                        r_ms        <= '0;
                        r_restart   <= 1'b1;
                        r_state     <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (r_sync2 != '0) begin
                        r_ms      <= '0;
                        r_restart <= 1'b1;
                    end else if (w_tick) begin
                        if (r_ms == MS_LAST) begin
                            r_ms      <= '0;
                            r_restart <= 1'b1;
                            r_state   <= IDLE;
                        end else begin
                            r_ms <= r_ms + 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
